// File: rtl/float_pkg.sv
// Shared FPU types and constants.
// Used by float_unpack and float_to_int.
package float_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exponent;
        logic [22:0] fraction;
    } float32_t;

    typedef enum logic [2:0] {
        ZERO,
        SMALL,
        NORMAL,
        BIG,
        INF,
        NAN
    } floatClass_t;

    localparam int FLOAT_BIAS = 127;
    localparam int EXP_NORM_MIN = FLOAT_BIAS - 1;
    localparam int EXP_NORM_MAX = FLOAT_BIAS + 30;

    localparam logic [31:0] INT32_MAX = 32'h7FFFFFFF;
    localparam logic [31:0] INT32_MIN = 32'h80000000;

endpackage

// File: rtl/float_unpack.sv
// Combinational unpack/classify of a single-precision float.
// Reusable by any FPU consumer that needs the operand class.
module float_unpack
    import float_pkg::*;
(
    input  float32_t         a,
    output logic             sign,
    output logic [7:0]       exponent,
    output logic [23:0]      mantissa,
    output floatClass_t      cls
);

    logic fracNz;

    assign sign     = a.sign;
    assign exponent = a.exponent;
    assign mantissa = {1'b1, a.fraction};
    assign fracNz   = |a.fraction;

    // Exclusive classification by exponent range
    always_comb begin
        cls = ZERO;
        unique case (1'b1)
            (a.exponent == 8'd0):
                cls = ZERO;
            (a.exponent == 8'hFF && fracNz):
                cls = NAN;
            (a.exponent == 8'hFF && !fracNz):
                cls = INF;
            (a.exponent != 8'd0 &&
             a.exponent < 8'(EXP_NORM_MIN)):
                cls = SMALL;
            (a.exponent >= 8'(EXP_NORM_MIN) &&
             a.exponent <= 8'(EXP_NORM_MAX)):
                cls = NORMAL;
            (a.exponent > 8'(EXP_NORM_MAX) &&
             a.exponent != 8'hFF):
                cls = BIG;
            default:
                cls = ZERO;
        endcase
    end

endmodule

// File: rtl/float_to_int.sv
// 3-stage float32 -> int32 converter, round-to-nearest-even, saturating.
// Define FLOAT_TO_INT_FLAGS_EN to build the invalid/inexact flag ports.
module float_to_int
    import float_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] result,
    output logic        out_valid,
    input  logic        out_ready
`ifdef FLOAT_TO_INT_FLAGS_EN
    ,
    output logic        invalid,
    output logic        inexact
`endif
);

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    logic        uSign;
    logic [7:0]  uExp;
    logic [23:0] uMant;
    floatClass_t uCls;

    float_unpack unpack (
        .a        (float32_t'(a)),
        .sign     (uSign),
        .exponent (uExp),
        .mantissa (uMant),
        .cls      (uCls)
    );

    logic        s1Valid;
    logic        s1Sign;
    logic [7:0]  s1Exp;
    logic [23:0] s1Mant;
    floatClass_t s1Cls;

    // Stage 1 register: unpacked operand
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1Valid <= 1'b0;
            s1Sign  <= 1'b0;
            s1Exp   <= 8'd0;
            s1Mant  <= 24'd0;
            s1Cls   <= ZERO;
        end else if (advance) begin
            s1Valid <= in_valid;
            s1Sign  <= uSign;
            s1Exp   <= uExp;
            s1Mant  <= uMant;
            s1Cls   <= uCls;
        end
    end

    logic [4:0]  shiftAmt;
    logic [63:0] alignW;
    logic [31:0] aMag;
    logic        aRnd;
    logic        aSt;

    assign shiftAmt = 5'(8'(EXP_NORM_MAX) - s1Exp);
    assign alignW   = {1'b0, s1Mant, 39'b0} >> shiftAmt;

    // Align: split into integer magnitude, round and sticky
    always_comb begin
        aMag = 32'd0;
        aRnd = 1'b0;
        aSt  = 1'b0;
        unique case (s1Cls)
            NORMAL: begin
                aMag = alignW[63:32];
                aRnd = alignW[31];
                aSt  = |alignW[30:0];
            end
            ZERO, SMALL:
                aSt = (s1Exp != 8'd0) ||
                      (s1Mant[22:0] != 23'd0);
            default: ;
        endcase
    end

    logic        s2Valid;
    logic        s2Sign;
    logic [31:0] s2Mag;
    logic        s2Rnd;
    logic        s2St;
    floatClass_t s2Cls;

    // Stage 2 register: aligned magnitude
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2Valid <= 1'b0;
            s2Sign  <= 1'b0;
            s2Mag   <= 32'd0;
            s2Rnd   <= 1'b0;
            s2St    <= 1'b0;
            s2Cls   <= ZERO;
        end else if (advance) begin
            s2Valid <= s1Valid;
            s2Sign  <= s1Sign;
            s2Mag   <= aMag;
            s2Rnd   <= aRnd;
            s2St    <= aSt;
            s2Cls   <= s1Cls;
        end
    end

    logic        rndUp;
    logic [31:0] magR;
    logic [31:0] nxtResult;

    assign rndUp = s2Rnd && (s2St || s2Mag[0]);
    assign magR  = s2Mag + {31'd0, rndUp};

    // Round, apply sign, saturate specials
    always_comb begin
        nxtResult = 32'd0;
        unique case (s2Cls)
            NAN:
                nxtResult = INT32_MAX;
            INF, BIG:
                nxtResult = s2Sign ? INT32_MIN : INT32_MAX;
            default:
                nxtResult = s2Sign ? -magR : magR;
        endcase
    end

    // Output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= 32'd0;
        end else if (advance) begin
            out_valid <= s2Valid;
            result    <= nxtResult;
        end
    end

`ifdef FLOAT_TO_INT_FLAGS_EN
    logic s2NegMin;
    logic aNegMin;
    logic nxtInvalid;
    logic nxtInexact;

    // -2^31 is exactly representable: not an invalid conversion
    assign aNegMin = s1Sign && (s1Exp == 8'(EXP_NORM_MAX + 1)) &&
                     (s1Mant[22:0] == 23'd0);

    assign nxtInvalid = (s2Cls == NAN) || (s2Cls == INF) ||
                        ((s2Cls == BIG) && !s2NegMin);
    assign nxtInexact = (s2Rnd || s2St) && !nxtInvalid;

    // Flag pipeline tracks the data pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2NegMin <= 1'b0;
            invalid  <= 1'b0;
            inexact  <= 1'b0;
        end else if (advance) begin
            s2NegMin <= aNegMin;
            invalid  <= nxtInvalid;
            inexact  <= nxtInexact;
        end
    end
`endif

endmodule

// File: tb/tb_float_to_int.sv
// Self-checking bench for float_to_int: vector table, random
// vectors against a reference model, stall and reset sequences.
module tb_float_to_int;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic        out_valid;
    logic        out_ready;
`ifdef FLOAT_TO_INT_FLAGS_EN
    logic        invalid;
    logic        inexact;
`endif

    float_to_int dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef FLOAT_TO_INT_FLAGS_EN
        ,
        .invalid   (invalid),
        .inexact   (inexact)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        inv;
        logic        inx;
    } expT;

    typedef struct {
        logic [31:0] a;
        logic [31:0] res;
        logic        inv;
        logic        inx;
    } vecT;

    expT expQ[$];
    int nChecks = 0;
    int nFails  = 0;
    logic        heldValid = 1'b0;
    logic [31:0] heldRes;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("FAIL %s: got %08h want %08h", name, act, req);
        end
    endtask

    // Independent reference: value = m * 2^(e-150)
    function automatic expT model(input logic [31:0] x);
        expT r;
        logic s;
        int e;
        logic [63:0] m, q, rem, half;
        int sh;
        s = x[31];
        e = int'(x[30:23]);
        m = {40'd0, 1'b1, x[22:0]};
        r.inv = 1'b0;
        r.inx = 1'b0;
        r.res = 32'd0;
        if (e == 255) begin
            r.res = (x[22:0] != 0) ? 32'h7FFFFFFF :
                    (s ? 32'h80000000 : 32'h7FFFFFFF);
            r.inv = 1'b1;
        end else if (e >= 158) begin
            r.res = s ? 32'h80000000 : 32'h7FFFFFFF;
            r.inv = (x != 32'hCF000000);
        end else if (e == 0) begin
            r.inx = (x[22:0] != 0);
        end else if (e < 126) begin
            r.inx = 1'b1;
        end else begin
            if (e >= 150) begin
                q = m << (e - 150);
            end else begin
                sh = 150 - e;
                q = m >> sh;
                rem = m & ((64'd1 << sh) - 64'd1);
                half = 64'd1 << (sh - 1);
                if (rem > half || (rem == half && q[0]))
                    q = q + 64'd1;
                r.inx = (rem != 0);
            end
            r.res = s ? -q[31:0] : q[31:0];
        end
        return r;
    endfunction

    // One cycle: drive at negedge, observe 1 time unit later
    task automatic step(input logic v,
                        input logic [31:0] din,
                        input expT ex,
                        input logic rdy,
                        output logic acc);
        expT got;
        @(negedge clk);
        in_valid  = v;
        a         = din;
        out_ready = rdy;
        #1;
        if (out_valid && !out_ready) begin
            if (heldValid) begin
                chk("stall_result", result, heldRes);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
            end
            heldValid = 1'b1;
            heldRes   = result;
        end else begin
            heldValid = 1'b0;
        end
        if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL extra_output: got %08h want none",
                         result);
            end else begin
                got = expQ.pop_front();
                chk("result", result, got.res);
`ifdef FLOAT_TO_INT_FLAGS_EN
                chk("invalid", 32'(invalid), 32'(got.inv));
                chk("inexact", 32'(inexact), 32'(got.inx));
`endif
            end
        end
        acc = in_valid && in_ready;
        if (acc) expQ.push_back(ex);
    endtask

    task automatic drain();
        logic acc;
        expT z;
        z = '{32'd0, 1'b0, 1'b0};
        for (int i = 0; i < 20 && expQ.size() != 0; i++)
            step(1'b0, 32'd0, z, 1'b1, acc);
        chk("drain_left", 32'(expQ.size()), 32'd0);
    endtask

    vecT vecs[$];
    logic [31:0] stream[8];

    initial begin
        logic acc;
        expT z;
        int idx;
        logic [31:0] x;
        z = '{32'd0, 1'b0, 1'b0};

        vecs = '{
            '{32'h3FC00000, 32'h00000002, 1'b0, 1'b1},
            '{32'h40200000, 32'h00000002, 1'b0, 1'b1},
            '{32'hC0600000, 32'hFFFFFFFC, 1'b0, 1'b1},
            '{32'h3F000000, 32'h00000000, 1'b0, 1'b1},
            '{32'h80000000, 32'h00000000, 1'b0, 1'b0},
            '{32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0},
            '{32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0},
            '{32'hCF000000, 32'h80000000, 1'b0, 1'b0},
            '{32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b0},
            '{32'hFF800000, 32'h80000000, 1'b1, 1'b0},
            '{32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0},
            '{32'hCF000001, 32'h80000000, 1'b1, 1'b0},
            '{32'h3F800000, 32'h00000001, 1'b0, 1'b0},
            '{32'hBFC00000, 32'hFFFFFFFE, 1'b0, 1'b1},
            '{32'h00000001, 32'h00000000, 1'b0, 1'b1},
            '{32'h3F000001, 32'h00000001, 1'b0, 1'b1},
            '{32'h3EFFFFFF, 32'h00000000, 1'b0, 1'b1},
            '{32'h4B000001, 32'h00800001, 1'b0, 1'b0}
        };

        reset = 1'b1;
        in_valid = 1'b0;
        a = 32'd0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
`ifdef FLOAT_TO_INT_FLAGS_EN
        chk("rst_invalid", 32'(invalid), 32'd0);
        chk("rst_inexact", 32'(inexact), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Latency: one conversion, out_valid on 3rd cycle
        step(1'b1, vecs[0].a,
             '{vecs[0].res, vecs[0].inv, vecs[0].inx},
             1'b1, acc);
        chk("lat_accept", 32'(acc), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 32'd0, z, 1'b1, acc);
            chk("lat_valid", 32'(out_valid), 32'(k == 3));
        end
        drain();

        // Table vectors, back to back
        for (int i = 0; i < vecs.size(); i++) begin
            acc = 1'b0;
            for (int t = 0; t < 10 && !acc; t++)
                step(1'b1, vecs[i].a,
                     '{vecs[i].res, vecs[i].inv, vecs[i].inx},
                     1'b1, acc);
            chk("tbl_accept", 32'(acc), 32'd1);
        end
        drain();

        // Random operands around the integer range
        for (int i = 0; i < 24; i++) begin
            x = {1'($urandom), 8'($urandom_range(120, 160)),
                 23'($urandom)};
            step(1'b1, x, model(x), 1'b1, acc);
        end
        drain();

        // Stream of 8 with a 5-cycle consumer stall mid-stream
        for (int i = 0; i < 8; i++)
            stream[i] = {1'($urandom), 8'($urandom_range(126, 157)),
                         23'($urandom)};
        idx = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            step(1'b1, stream[idx], model(stream[idx]),
                 !(c >= 4 && c < 9), acc);
            if (acc) idx++;
        end
        chk("stream_sent", 32'(idx), 32'd8);
        drain();

        // Reset with 3 conversions in flight
        for (int i = 0; i < 3; i++)
            step(1'b1, vecs[i + 2].a, z, 1'b1, acc);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        expQ.delete();
        heldValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'd0, z, 1'b1, acc);
            chk("post_rst_quiet", 32'(out_valid), 32'd0);
        end

        // Pipeline still works after reset
        step(1'b1, 32'h40200000, model(32'h40200000), 1'b1, acc);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got hang want finish");
        $fatal(1);
    end

endmodule

// File: doc/float_to_int.md
# float_to_int

Pipelined IEEE-754 single-precision to 32-bit signed two's-complement integer converter. It performs the inverse of the integer-to-float conversion path and sits on the FPU result side, feeding the integer register write-back. Rounding is round-to-nearest-even. Out-of-range, infinite and NaN inputs saturate. Valid/ready handshakes on both sides allow stalls from the consumer.

## Interface
- No parameters (widths fixed: 32-bit float in, 32-bit signed integer out).
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all pipeline valid bits and output registers.
- a  input  32  float operand {sign, exponent[7:0], fraction[22:0]}.
- in_valid  input  1  operand `a` is valid this cycle.
- in_ready  output  1  block accepts `a` this cycle.
- result  output  32  signed integer result.
- out_valid  output  1  `result` (and flags) valid.
- out_ready  input  1  consumer accepts `result` this cycle.
- invalid  output  1  NaN, infinity or out-of-range input (only with FLOAT_TO_INT_FLAGS_EN).
- inexact  output  1  result differs from the exact input value (only with FLOAT_TO_INT_FLAGS_EN).

## Operation
- Stage 1 (unpack/classify): sign s, exponent e, mantissa m = {1, fraction}. Classes:
  - zero/denormal: e == 0.
  - NaN: e == 255, fraction != 0.
  - inf: e == 255, fraction == 0.
  - small: e < 126.
  - normal range: 126 ≤ e ≤ 157.
  - big: 158 ≤ e ≤ 254.
- Stage 2 (align): for normal range, W[63:0] = {1'b0, m, 39'b0} >> (157 − e); shift amount 0..31 (5 bits).
  - Integer magnitude mag = W[63:32], round bit r = W[31], sticky st = |W[30:0].
  - For small/denormal: mag = 0, r = 0, st = (e != 0 or fraction != 0).
- Stage 3 (round/sign/saturate):
  - Increment mag when r & (st | mag[0]). Rounding never exceeds 2^31 − 1, because e = 157 always has r = 0.
  - result = s ? −mag : mag. −0 gives 0x00000000.
  - Saturation:
    - NaN → 0x7FFFFFFF.
    - +inf or positive big → 0x7FFFFFFF.
    - −inf or negative big → 0x80000000.
    - Exactly 0xCF000000 (−2^31) → 0x80000000 with invalid = 0.
  - invalid = NaN | inf | (big and not exactly −2^31).
  - inexact = (r | st) & !invalid.

## Timing
- Latency: 3 cycles from the in_valid & in_ready edge to out_valid, when unstalled.
- Throughput: 1 conversion per cycle.
- Global advance = !out_valid | out_ready.
  - in_ready = advance.
  - All three stage registers load only when advance = 1.
  - Bubbles are not collapsed.
- While out_valid & !out_ready:
  - result and flags hold stable.
  - in_ready = 0.
  - No state changes.
- Simultaneous accept and deliver in one cycle is legal. Back-to-back streams produce back-to-back outputs.
- Reset values: out_valid = 0, result = 0x00000000, invalid = 0, inexact = 0, all internal valid bits 0.
  - in_ready = 1 in the first cycle after reset deasserts.
- Reset mid-stream discards every in-flight conversion. No partial output is produced.

## Configuration
- FLOAT_TO_INT_FLAGS_EN defined: the invalid and inexact ports exist and are pipelined alongside result with identical timing.
- Not defined:
  - The invalid and inexact ports are absent.
  - No flag logic or registers are built.
  - result values and saturation are unchanged.

## Structure
- Shared package float_pkg:
  - float32_t packed struct {sign, exponent[7:0], fraction[22:0]}.
  - FLOAT_BIAS = 127.
  - INT32_MAX = 32'h7FFFFFFF, INT32_MIN = 32'h80000000.
  - Class enum: ZERO, SMALL, NORMAL, BIG, INF, NAN.
- One sub-module float_unpack: combinational stage-1 classify/unpack logic, reusable by other FPU consumers.
- Stages 2 and 3 are written inline.

## Test plan
- 0x3FC00000 (1.5) → 0x00000002, inexact = 1. Then 0x40200000 (2.5) → 0x00000002, inexact = 1 (ties to even).
- 0xC0600000 (−3.5) → 0xFFFFFFFC. 0x3F000000 (0.5) → 0x00000000, inexact = 1. 0x80000000 (−0) → 0x00000000, no flags.
- 0x4EFFFFFF → 0x7FFFFF80 exact. 0x4F000000 → 0x7FFFFFFF, invalid = 1. 0xCF000000 → 0x80000000, invalid = 0.
- 0x7FC00000 (NaN) → 0x7FFFFFFF. 0xFF800000 (−inf) → 0x80000000. Both set invalid = 1.
- Stream of 8 inputs with out_ready low for 5 cycles mid-stream: outputs arrive in order with none lost or duplicated, and result stays stable while stalled.
- Reset asserted with 3 conversions in flight: out_valid drops immediately, and no stale result appears after reset releases.
